// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and helpers for the multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    // Widest operand abs_val handles; callers zero-extend into it and truncate back.
    localparam int ABS_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } muldiv_state_t;

    function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] v, input logic neg);
        return neg ? (~v + {{(ABS_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    assign shifted  = {rem, dvd_bit};
    assign q_bit    = (shifted >= {1'b0, divisor});
    // When the subtract is taken the result is below the divisor, so the low bits suffice.
    assign diff     = shifted[WIDTH-1:0] - divisor;
    assign rem_next = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Iterative mult/div sequencer owning HI/LO for the execute stage.
// Build option MULDIV_FAST_MUL_EN: single-cycle multiplier replaces the shift-add MUL loop.
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t      state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand, divisor, rem, quot;
    logic               sign_a, sign_b, op_div;

    logic               is_mul, is_div, is_sgn, is_mthi, is_mtlo;
    logic               go_mul, go_div, commit, busy_next, done_next;
    logic               wr_hi, wr_lo;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   rem_nxt;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign is_mul  = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    assign is_div  = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    assign is_sgn  = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign is_mthi = (funct == FUNCT_MTHI);
    assign is_mtlo = (funct == FUNCT_MTLO);

    assign neg_a = is_sgn & opa[WIDTH-1];
    assign neg_b = is_sgn & opb[WIDTH-1];
    assign a_mag = WIDTH'(abs_val(ABS_W'(opa), neg_a));
    assign b_mag = WIDTH'(abs_val(ABS_W'(opb), neg_b));

    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem),
        .dvd_bit  (quot[WIDTH-1]),
        .divisor  (divisor),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    assign prod_fix = (sign_a ^ sign_b) ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;
    assign quot_fix = (sign_a ^ sign_b) ? (~quot + {{(WIDTH-1){1'b0}}, 1'b1}) : quot;
    assign rem_fix  = sign_a ? (~rem + {{(WIDTH-1){1'b0}}, 1'b1}) : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_next  = busy;
        done_next  = 1'b0;
        go_mul     = 1'b0;
        go_div     = 1'b0;
        commit     = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        if (flush) begin
            state_next = IDLE;
            busy_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && is_mul) begin
                        go_mul    = 1'b1;
                        busy_next = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        state_next = FIX;
`else
                        state_next = MUL;
`endif
                    end else if (start && is_div) begin
                        go_div     = 1'b1;
                        busy_next  = 1'b1;
                        state_next = DIV;
                    end else begin
                        wr_hi = start & is_mthi;
                        wr_lo = start & is_mtlo;
                    end
                end
                MUL, DIV: begin
                    if (cnt == '0) state_next = FIX;
                end
                FIX: begin
                    commit     = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            divisor <= '0;
            rem     <= '0;
            quot    <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            op_div  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (go_mul || go_div) begin
                cnt    <= CNT_W'(WIDTH-1);
                sign_a <= neg_a;
                sign_b <= neg_b;
                op_div <= go_div;
            end
            if (go_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                acc <= (2*WIDTH)'(a_mag) * (2*WIDTH)'(b_mag);
`else
                acc   <= {{WIDTH{1'b0}}, b_mag};
                mcand <= a_mag;
`endif
            end
            if (go_div) begin
                divisor <= b_mag;
                quot    <= a_mag;
                rem     <= '0;
            end
            if (!flush && (state == MUL || state == DIV) && cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (!flush && state == MUL)
                acc <= {mul_sum, acc[WIDTH-1:1]};
            if (!flush && state == DIV) begin
                rem  <= rem_nxt;
                quot <= {quot[WIDTH-2:0], q_bit};
            end
            if (wr_hi) hi <= opa;
            if (wr_lo) lo <= opa;
            if (commit) begin
                if (op_div) begin
                    hi <= rem_fix;
                    lo <= quot_fix;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl (WIDTH=32, iterative multiply build).
module tb_muldiv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] opa, opb;
    logic        flush;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_seq_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .funct (funct),
        .opa   (opa),
        .opb   (opb),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge (E0), then wait for done; edges counts E0 onward.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_cyc);
        funct = f; opa = a; opb = b; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        busy_cyc = busy ? 1 : 0;
        while (!done && edges < 200) begin
            tick();
            edges++;
            if (busy) busy_cyc++;
        end
    endtask

    int  edges, busy_cyc;
    logic saw_done;

    initial begin
        rst = 1'b1; start = 1'b0; funct = '0; opa = '0; opb = '0; flush = 1'b0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_op(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, busy_cyc);
        chk("multu_latency", edges, 34);
        chk("multu_busy_cycles", busy_cyc, 33);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        tick();
        chk("done_one_pulse", done, 0);

        run_op(6'b011000, 32'hFFFF_FFFD, 32'd7, edges, busy_cyc);
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFEB);

        run_op(6'b011010, 32'hFFFF_FFF9, 32'd2, edges, busy_cyc);
        chk("div_latency", edges, 34);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);

        run_op(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, edges, busy_cyc);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0);

        run_op(6'b011011, 32'd100, 32'd0, edges, busy_cyc);
        chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
        chk("divu_zero_hi", hi, 32'd100);

        run_op(6'b011011, 32'd100, 32'd7, edges, busy_cyc);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        // mthi / mtlo land at the next edge without stalling
        funct = 6'b010001; opa = 32'h1234; start = 1'b1;
        tick();
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", busy, 0);
        funct = 6'b010011; opa = 32'h5678;
        tick();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h5678);
        chk("mtlo_hi_kept", hi, 32'h1234);
        chk("mtlo_done", done, 0);

        // unknown funct is ignored
        funct = 6'b100000; opa = 32'hDEAD; opb = 32'h1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("bad_funct_busy", busy, 0);
        chk("bad_funct_lo", lo, 32'h5678);

        // divu presented mid-mult is dropped
        funct = 6'b011001; opa = 32'd3; opb = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        funct = 6'b011011; opa = 32'd100; opb = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        while (!done && edges < 100) begin
            tick();
            edges++;
        end
        chk("mid_mult_done", done, 1);
        chk("mid_mult_lo", lo, 32'd15);
        chk("mid_mult_hi", hi, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        chk("mid_divu_dropped", saw_done, 0);
        chk("mid_divu_lo_kept", lo, 32'd15);

        // flush during div keeps preloaded hi/lo
        funct = 6'b010001; opa = 32'hAAAA; start = 1'b1;
        tick();
        funct = 6'b010011; opa = 32'h5555;
        tick();
        funct = 6'b011011; opa = 32'd100; opb = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("flush_no_done", saw_done, 0);
        chk("flush_hi", hi, 32'hAAAA);
        chk("flush_lo", lo, 32'h5555);

        // flush in IDLE blocks a same-cycle start
        funct = 6'b010001; opa = 32'h7777; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_blocks_mthi", hi, 32'hAAAA);

        // async reset mid-mult
        funct = 6'b011000; opa = 32'd9; opb = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_hi", hi, 0);
        chk("rst_mid_lo", lo, 0);
        chk("rst_mid_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) tick();
        chk("rst_no_commit", lo, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
- Iterative multiply/divide sequencer and HI/LO register owner for the MIPS core's execute stage.
- Accepts R-type mult/multu/div/divu/mthi/mtlo dispatched by funct code and runs a multi-cycle shift-add or restoring-divide sequence.
- Holds the execute stage through a busy/stall output until the result is committed, then pulses done.
- Serves mfhi/mflo through the combinational hi/lo outputs.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and at least 4.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  dispatch strobe; sampled only in IDLE.
- funct  input  6  R-type function code selecting the operation.
- opa  input  WIDTH  rs value (multiplicand / dividend / mthi-mtlo source).
- opb  input  WIDTH  rt value (multiplier / divisor).
- flush  input  1  pipeline flush; aborts any sequence in flight.
- busy  output  1  registered; high while a sequence is in flight; drives stall.
- done  output  1  one-cycle pulse when HI/LO commit from a mult/div.
- hi  output  WIDTH  HI register (mfhi source).
- lo  output  WIDTH  LO register (mflo source).

Behaviour:
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, working registers=0.
- Funct codes: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo. Any other funct with start is ignored (no state change).
- States: IDLE, MUL, DIV, FIX.
- IDLE, start with mthi/mtlo: hi (or lo) <= opa at that edge. No busy, no done.
- IDLE, start with mult/multu: latch operands, counter <= WIDTH-1, go to MUL, busy <= 1.
- IDLE, start with div/divu: same latching and counter load, go to DIV, busy <= 1.
- Signed ops (mult, div): operate on magnitudes and record the operand sign bits. Unsigned ops treat operands as-is.
- MUL: one radix-2 shift-add step per cycle on a 2*WIDTH accumulator.
- DIV: one restoring step per cycle on a WIDTH remainder plus WIDTH quotient.
- MUL/DIV transitions: when counter==0, go to FIX; otherwise decrement the counter.
- FIX: apply sign correction and write {hi,lo}.
  - Product: negate the full 2*WIDTH value if the signs differ.
  - Quotient: negative if the signs differ.
  - Remainder: takes the dividend's sign.
  - Results: lo=quotient, hi=remainder; or hi=product[2W-1:W], lo=product[W-1:0].
  - At that same edge: busy <= 0, done <= 1 for one cycle, state <= IDLE.
- Latency: start sampled at edge E0; WIDTH iteration edges E1..E_W; FIX commit at E_(W+1). hi/lo and done are valid in the cycle after E_(W+1) (34 cycles for WIDTH=32). busy is high in cycles after E0 through E_W.
- start while busy: ignored. The upstream stage is stalled and must re-present the request.
- Divide by zero (opb==0): no trap; natural restoring result.
  - Unsigned: lo=all-ones, hi=opa.
  - Signed: the same magnitudes, then the normal sign fix-up.
- Signed overflow, most-negative / -1: lo=0x80000000, hi=0 (truncated magnitude arithmetic).
- flush: in any non-IDLE state, go to IDLE next edge, busy <= 0, no done, hi/lo unchanged. In IDLE it blocks a same-cycle start (flush has priority). flush and FIX in the same cycle: flush wins, no commit.
- Async reset mid-sequence: immediate return to reset values; the partial result is discarded.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
  - Defined: mult/multu bypass MUL. The product is computed with a single-cycle multiplier and committed through FIX at E1, so done is valid after E1 and busy is high for one cycle. Division is unchanged.
  - Undefined: iterative MUL path as above; no hardware multiplier is inferred.

Decomposition:
- Package muldiv_pkg:
  - funct constants: FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO.
  - state enum muldiv_state_t {IDLE, MUL, DIV, FIX}.
  - helper function abs_val.
- One sub-module, div_step: combinational single restoring-division step. Inputs: remainder, dividend bit, divisor. Outputs: next remainder and quotient bit. Reusable by a future radix-4 variant.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> done exactly 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- mult 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu 100 / 0 -> lo=0xFFFFFFFF, hi=100.
- mthi 0x1234 then mtlo 0x5678 in IDLE -> hi/lo update next edge with no busy or done. A second start (divu) issued mid-mult is ignored: the mult result commits and no divu result appears.
- Assert flush at cycle 10 of div with hi/lo preloaded to 0xAAAA/0x5555 -> IDLE next edge, no done, hi/lo keep 0xAAAA/0x5555. Assert rst mid-mult -> all outputs 0 immediately.
